count_display_7seg: RTL and testbench
=====================================

# count_display_7seg

Downstream display stage for the debounced push-button counter. Takes the binary count and converts it to two BCD digits with a serial double-dabble converter. Drives a two-digit, common-anode, time-multiplexed 7-segment display, so the count is readable in decimal alongside or instead of the raw LED bits. All outputs are registered and active-low, matching the board's LED polarity.

## Interface

- WIDTH, 6: bit width of `value`; legal range 1..7; out-of-range is an elaboration error.
- SCAN_DIV, 27000: clock cycles each digit stays lit; legal minimum 2.
- clk  input  1  system clock; one clock domain, everything on rising edge.
- rst  input  1  reset, synchronous and active-low.
- value  input  WIDTH  binary count to display; synchronous to clk.
- seg  output  7  segments {g,f,e,d,c,b,a}, active-low.
- an  output  2  digit anodes, active-low; an[0] = units, an[1] = tens.
- busy  output  1  high while a conversion is in progress.

## Operation

- Converter FSM states and transitions:
  - IDLE → CONV when `value` != `shadow`. On that edge, capture `value` into `shadow` and into the shift register, and clear the BCD nibbles.
  - CONV: one double-dabble step per cycle. Each step first adds 3 to any nibble ≥ 5, then shifts left by 1. Run exactly WIDTH steps, then go to DONE.
  - DONE: load `tens_q`/`units_q` from the BCD nibbles, then return to IDLE.
- `value` changes during CONV or DONE are ignored. The IDLE compare against `shadow` picks up the latest value afterwards, so the final stable value is always displayed.
- Overflow: if `shadow` > 99 (possible only when WIDTH=7), DONE loads the dash code into both digits.
- Scan counter runs 0..SCAN_DIV-1. At terminal count it wraps to 0 and toggles `dsel`.
- `an` is 2'b10 when dsel=0 and 2'b01 when dsel=1.
- `seg` is the decoded `units_q` or `tens_q` for the selected digit.
- Segment codes:
  - 0 = 1000000, 1 = 1111001, 2 = 0100100, 3 = 0110000, 4 = 0011001
  - 5 = 0010010, 6 = 0000010, 7 = 1111000, 8 = 0000000, 9 = 0010000
  - dash = 0111111, blank = 1111111
- Reset mid-conversion aborts CONV and clears all state; no partial result is ever loaded.

## Timing

- Reset values while rst=0:
  - seg = 7'h7F, an = 2'b11, busy = 0.
  - FSM in IDLE; shadow, tens_q, units_q, scan counter and dsel all 0.
- Cycle after rst rises: an = 2'b10, seg = code for units digit 0. The post-reset display is "00", or blank/0 under the macro.
- If `value` differs from `shadow` at edge k (FSM in IDLE):
  - busy is high from after edge k through edge k+WIDTH+1.
  - tens_q/units_q update at edge k+WIDTH+1.
  - `seg` shows the new digit at edge k+WIDTH+2 if that digit is selected. Otherwise it shows at the first edge after the digit becomes selected.
- Latency with the default WIDTH=6: 8 cycles from value change to `seg`, worst case plus one scan period.
- `an` and `seg` change on the same edge, so there is no cross-digit ghost cycle.
- Scan period is 2·SCAN_DIV cycles; each digit is lit for exactly SCAN_DIV cycles.

## Configuration

- LEADING_ZERO_BLANK_EN:
  - Defined: when tens_q = 0 (and not overflow), the tens digit drives blank (7'h7F) while selected. `an` still scans normally.
  - Undefined: the tens digit always shows its numeral, including 0.
- Only the decode path changes; latency and FSM are identical in both builds.

## Structure

- Package `display_pkg`:
  - Typedef `conv_state_t` {IDLE, CONV, DONE}.
  - 7-bit segment constants SEG_0..SEG_9, SEG_DASH, SEG_BLANK.
  - Anode constants AN_UNITS = 2'b10, AN_TENS = 2'b01, AN_OFF = 2'b11.
- Sub-module `bin2bcd_serial`:
  - Holds the FSM, shadow register, shift register, step counter and overflow flag.
  - Outputs `busy`, `tens`, `units`, `ovf` and `load` (one-cycle strobe in DONE).
- The top keeps the scan counter, digit registers, segment decoder and the output registers.

## Test plan

- Reset: hold rst=0 for 3 cycles with value=6'd37 → seg=7'h7F, an=2'b11, busy=0. After release, units digit 0 appears on an=2'b10, then busy rises for 7 cycles while 37 converts.
- Conversion (SCAN_DIV=4): value=6'd37 → busy high 7 cycles. Then an=2'b10 shows seg=1111000 (7) and an=2'b01 shows seg=0110000 (3).
- Scan (SCAN_DIV=4): an sequence per cycle is 10,10,10,10,01,01,01,01,10…, with seg switching on the same edges.
- Mid-conversion change: value 12→45 two cycles after busy rises → display "12" at k+8, then busy again, then "45" 8 cycles later.
- Overflow (WIDTH=7): value=7'd100 → both digits seg=0111111. Value=7'd99 → both digits seg=0010000.
- Macro: value=6'd5 → tens digit (an=2'b01) seg=1111111 with LEADING_ZERO_BLANK_EN, 1000000 without. Units digit is 0010010 in both builds.

Source files
------------

// File: rtl/display_pkg.sv
// Shared types and constants for the two-digit 7-segment count display.
// Segment codes are {g,f,e,d,c,b,a}, active-low; anode codes are active-low.
package display_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CONV = 2'd1,
    DONE = 2'd2
  } conv_state_t;

  localparam logic [6:0] SEG_0     = 7'b1000000;
  localparam logic [6:0] SEG_1     = 7'b1111001;
  localparam logic [6:0] SEG_2     = 7'b0100100;
  localparam logic [6:0] SEG_3     = 7'b0110000;
  localparam logic [6:0] SEG_4     = 7'b0011001;
  localparam logic [6:0] SEG_5     = 7'b0010010;
  localparam logic [6:0] SEG_6     = 7'b0000010;
  localparam logic [6:0] SEG_7     = 7'b1111000;
  localparam logic [6:0] SEG_8     = 7'b0000000;
  localparam logic [6:0] SEG_9     = 7'b0010000;
  localparam logic [6:0] SEG_DASH  = 7'b0111111;
  localparam logic [6:0] SEG_BLANK = 7'b1111111;

  localparam logic [1:0] AN_UNITS = 2'b10;
  localparam logic [1:0] AN_TENS  = 2'b01;
  localparam logic [1:0] AN_OFF   = 2'b11;

  // Digit registers hold BCD 0..9 or this marker for the overflow dash.
  localparam logic [3:0] DIG_DASH = 4'hA;

  localparam int MAX_DISPLAY = 99;

  function automatic logic [6:0] seg_decode(input logic [3:0] digit);
    logic [6:0] code;
    case (digit)
      4'd0:     code = SEG_0;
      4'd1:     code = SEG_1;
      4'd2:     code = SEG_2;
      4'd3:     code = SEG_3;
      4'd4:     code = SEG_4;
      4'd5:     code = SEG_5;
      4'd6:     code = SEG_6;
      4'd7:     code = SEG_7;
      4'd8:     code = SEG_8;
      4'd9:     code = SEG_9;
      DIG_DASH: code = SEG_DASH;
      default:  code = SEG_BLANK;
    endcase
    return code;
  endfunction

endpackage : display_pkg

// File: rtl/count_display_7seg_bin2bcd.sv
// Serial double-dabble binary-to-BCD converter: one shift step per cycle,
// WIDTH steps per conversion, started whenever the input differs from the last one taken.
module bin2bcd_serial
  import display_pkg::*;
#(
  parameter int WIDTH = 6
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] value,
  output logic             busy,
  output logic [3:0]       tens,
  output logic [3:0]       units,
  output logic             ovf,
  output logic             load
);

  localparam logic [2:0] LAST_STEP = 3'(WIDTH - 1);

  conv_state_t      state_q;
  logic [WIDTH-1:0] shadow_q;
  logic [WIDTH-1:0] shift_q;
  logic [7:0]       bcd_q;
  logic [7:0]       bcd_adj;
  logic [2:0]       step_q;
  logic             busy_q;
  logic             load_q;

  // NOTE: every variable written here gets a default first so no latch is inferred.
  always_comb begin
    bcd_adj = bcd_q;
    if (bcd_q[3:0] >= 4'd5) bcd_adj[3:0] = bcd_q[3:0] + 4'd3;
    if (bcd_q[7:4] >= 4'd5) bcd_adj[7:4] = bcd_q[7:4] + 4'd3;
  end

  // NOTE: sequential state uses non-blocking assignments so all registers see pre-edge values.
  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q  <= IDLE;
      shadow_q <= '0;
      shift_q  <= '0;
      bcd_q    <= '0;
      step_q   <= '0;
      busy_q   <= 1'b0;
      load_q   <= 1'b0;
    end else begin
      load_q <= 1'b0;
      case (state_q)
        IDLE: begin
          if (value != shadow_q) begin
            state_q  <= CONV;
            shadow_q <= value;
            shift_q  <= value;
            bcd_q    <= '0;
            step_q   <= '0;
            busy_q   <= 1'b1;
          end
        end
        CONV: begin
          // Adjust-then-shift; the hundreds bit falls off, covered by the overflow flag.
          {bcd_q, shift_q} <= {bcd_adj, shift_q} << 1;
          step_q           <= step_q + 3'd1;
          if (step_q == LAST_STEP) begin
            state_q <= DONE;
            load_q  <= 1'b1;
          end
        end
        DONE: begin
          state_q <= IDLE;
          busy_q  <= 1'b0;
        end
        default: begin
          state_q <= IDLE;
          busy_q  <= 1'b0;
        end
      endcase
    end
  end

  assign busy  = busy_q;
  assign load  = load_q;
  assign tens  = bcd_q[7:4];
  assign units = bcd_q[3:0];
  assign ovf   = 8'(shadow_q) > 8'(MAX_DISPLAY);

endmodule : bin2bcd_serial

// File: rtl/count_display_7seg.sv
// Two-digit multiplexed common-anode display of a binary count in decimal.
// Optional LEADING_ZERO_BLANK_EN blanks a zero tens digit; otherwise the tens numeral always shows.
module count_display_7seg
  import display_pkg::*;
#(
  parameter int WIDTH    = 6,
  parameter int SCAN_DIV = 27000
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] value,
  output logic [6:0]       seg,
  output logic [1:0]       an,
  output logic             busy
);

  if (WIDTH < 1 || WIDTH > 7) begin : g_bad_width
    $error("count_display_7seg: WIDTH must be in 1..7");
  end
  if (SCAN_DIV < 2) begin : g_bad_scan
    $error("count_display_7seg: SCAN_DIV must be at least 2");
  end

  localparam int              SCAN_W    = $clog2(SCAN_DIV);
  localparam logic [SCAN_W-1:0] SCAN_LAST = SCAN_W'(SCAN_DIV - 1);

  logic       conv_busy;
  logic [3:0] conv_tens;
  logic [3:0] conv_units;
  logic       conv_ovf;
  logic       conv_load;

  bin2bcd_serial #(
    .WIDTH (WIDTH)
  ) u_bin2bcd (
    .clk   (clk),
    .rst   (rst),
    .value (value),
    .busy  (conv_busy),
    .tens  (conv_tens),
    .units (conv_units),
    .ovf   (conv_ovf),
    .load  (conv_load)
  );

  logic [SCAN_W-1:0] scan_q, scan_d;
  logic              dsel_q, dsel_d;
  logic [3:0]        tens_q, tens_d;
  logic [3:0]        units_q, units_d;
  logic [6:0]        seg_q, seg_d;
  logic [1:0]        an_q, an_d;

  always_comb begin
    scan_d = scan_q + SCAN_W'(1);
    dsel_d = dsel_q;
    if (scan_q == SCAN_LAST) begin
      scan_d = '0;
      dsel_d = ~dsel_q;
    end
  end

  always_comb begin
    tens_d  = tens_q;
    units_d = units_q;
    if (conv_load) begin
      if (conv_ovf) begin
        tens_d  = DIG_DASH;
        units_d = DIG_DASH;
      end else begin
        tens_d  = conv_tens;
        units_d = conv_units;
      end
    end
  end

  // an and seg are both derived from the current dsel so they switch on the same edge.
  always_comb begin
    an_d  = dsel_q ? AN_TENS : AN_UNITS;
    seg_d = seg_decode(dsel_q ? tens_q : units_q);
`ifdef LEADING_ZERO_BLANK_EN
    if (dsel_q && tens_q == 4'd0) seg_d = SEG_BLANK;
`endif
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      scan_q  <= '0;
      dsel_q  <= 1'b0;
      tens_q  <= '0;
      units_q <= '0;
      seg_q   <= SEG_BLANK;
      an_q    <= AN_OFF;
    end else begin
      scan_q  <= scan_d;
      dsel_q  <= dsel_d;
      tens_q  <= tens_d;
      units_q <= units_d;
      seg_q   <= seg_d;
      an_q    <= an_d;
    end
  end

  assign seg  = seg_q;
  assign an   = an_q;
  assign busy = conv_busy;

endmodule : count_display_7seg

// File: tb/tb_count_display_7seg.sv
// Bench for count_display_7seg: a WIDTH=6 and a WIDTH=7 instance, SCAN_DIV=4,
// expected digit pairs queued at stimulus time and compared while the display scans.
module tb_count_display_7seg;

  localparam int SCAN_DIV = 4;

  typedef struct {
    logic [6:0] tens;
    logic [6:0] units;
  } exp_t;

  logic       clk = 1'b0;
  logic       rst;
  logic [5:0] value6;
  logic [6:0] value7;
  logic [6:0] seg6, seg7;
  logic [1:0] an6, an7;
  logic       busy6, busy7;

  bit         sel7;
  logic [6:0] seg_o;
  logic [1:0] an_o;
  logic       busy_o;

  int   checks = 0;
  int   errors = 0;
  exp_t sb[$];

  always #5 clk = ~clk;

  count_display_7seg #(.WIDTH(6), .SCAN_DIV(SCAN_DIV)) dut6 (
    .clk(clk), .rst(rst), .value(value6), .seg(seg6), .an(an6), .busy(busy6)
  );

  count_display_7seg #(.WIDTH(7), .SCAN_DIV(SCAN_DIV)) dut7 (
    .clk(clk), .rst(rst), .value(value7), .seg(seg7), .an(an7), .busy(busy7)
  );

  assign seg_o  = sel7 ? seg7  : seg6;
  assign an_o   = sel7 ? an7   : an6;
  assign busy_o = sel7 ? busy7 : busy6;

  function automatic logic [6:0] seg_of(input int d);
    case (d)
      0: return 7'b1000000;
      1: return 7'b1111001;
      2: return 7'b0100100;
      3: return 7'b0110000;
      4: return 7'b0011001;
      5: return 7'b0010010;
      6: return 7'b0000010;
      7: return 7'b1111000;
      8: return 7'b0000000;
      9: return 7'b0010000;
      default: return 7'b1111111;
    endcase
  endfunction

  function automatic exp_t model(input int v);
    exp_t r;
    if (v > 99) begin
      r.tens  = 7'b0111111;
      r.units = 7'b0111111;
    end else begin
      r.tens  = seg_of(v / 10);
      r.units = seg_of(v % 10);
`ifdef LEADING_ZERO_BLANK_EN
      if (v / 10 == 0) r.tens = 7'b1111111;
`endif
    end
    return r;
  endfunction

  task automatic drive(input int v);
    if (sel7) value7 = 7'(v);
    else      value6 = 6'(v);
    sb.push_back(model(v));
  endtask

  // exp_len > 0: wait for busy and check how many more sampled cycles it stays high.
  // exp_len == 0: conversion is already complete; go straight to the display window.
  task automatic wait_result(input string name, input int exp_len);
    exp_t e;
    int   n;
    int   len;
    if (exp_len > 0) begin
      n = 0;
      while (busy_o !== 1'b1 && n < 10) begin
        @(negedge clk);
        n++;
      end
      checks++;
      if (busy_o !== 1'b1) begin
        errors++;
        $display("FAIL %s busy_rise: busy=%b required 1", name, busy_o);
      end
      len = 0;
      while (busy_o === 1'b1 && len < 40) begin
        @(negedge clk);
        len++;
      end
      checks++;
      if (len != exp_len) begin
        errors++;
        $display("FAIL %s busy_len: got %0d cycles required %0d", name, len, exp_len);
      end
    end
    checks++;
    if (sb.size() == 0) begin
      errors++;
      $display("FAIL %s scoreboard_empty: size=0 required >0", name);
      return;
    end
    e = sb.pop_front();
    for (int i = 0; i < 2 * SCAN_DIV; i++) begin
      @(negedge clk);
      checks++;
      if (an_o === 2'b10) begin
        if (seg_o !== e.units) begin
          errors++;
          $display("FAIL %s units[%0d]: seg=%b required %b", name, i, seg_o, e.units);
        end
      end else if (an_o === 2'b01) begin
        if (seg_o !== e.tens) begin
          errors++;
          $display("FAIL %s tens[%0d]: seg=%b required %b", name, i, seg_o, e.tens);
        end
      end else begin
        errors++;
        $display("FAIL %s anode[%0d]: an=%b required 10 or 01", name, i, an_o);
      end
    end
  endtask

  task automatic test_reset();
    exp_t z;
    z      = model(0);
    sel7   = 1'b0;
    value7 = 7'd0;
    value6 = 6'd37;
    rst    = 1'b0;
    repeat (3) @(negedge clk);
    checks++;
    if (seg_o !== 7'h7F || an_o !== 2'b11 || busy_o !== 1'b0) begin
      errors++;
      $display("FAIL reset_outputs: seg=%b an=%b busy=%b required 1111111 11 0",
               seg_o, an_o, busy_o);
    end
    drive(37);
    rst = 1'b1;
    @(negedge clk);
    checks++;
    if (an_o !== 2'b10 || seg_o !== z.units || busy_o !== 1'b1) begin
      errors++;
      $display("FAIL post_reset: an=%b seg=%b busy=%b required 10 %b 1",
               an_o, seg_o, busy_o, z.units);
    end
    wait_result("conv37", 7);
  endtask

  task automatic test_scan();
    exp_t z;
    logic [1:0] an_exp;
    logic [6:0] seg_exp;
    z      = model(0);
    sel7   = 1'b0;
    value6 = 6'd0;
    rst    = 1'b0;
    repeat (2) @(negedge clk);
    rst = 1'b1;
    for (int i = 0; i < 3 * 2 * SCAN_DIV; i++) begin
      @(negedge clk);
      an_exp  = ((i / SCAN_DIV) % 2 == 0) ? 2'b10 : 2'b01;
      seg_exp = ((i / SCAN_DIV) % 2 == 0) ? z.units : z.tens;
      checks++;
      if (an_o !== an_exp || seg_o !== seg_exp || busy_o !== 1'b0) begin
        errors++;
        $display("FAIL scan[%0d]: an=%b seg=%b busy=%b required %b %b 0",
                 i, an_o, seg_o, busy_o, an_exp, seg_exp);
      end
    end
  endtask

  task automatic test_conversion();
    sel7 = 1'b0;
    drive(63); wait_result("conv63", 7);
    drive(10); wait_result("conv10", 7);
    drive(0);  wait_result("conv0", 7);
    drive(58); wait_result("conv58", 7);
  endtask

  task automatic test_macro();
    sel7 = 1'b0;
    drive(5); wait_result("conv5", 7);
  endtask

  task automatic test_midconv();
    int n;
    sel7 = 1'b0;
    drive(12);
    n = 0;
    while (busy_o !== 1'b1 && n < 10) begin
      @(negedge clk);
      n++;
    end
    checks++;
    if (busy_o !== 1'b1) begin
      errors++;
      $display("FAIL mid_busy_rise: busy=%b required 1", busy_o);
    end
    repeat (2) @(negedge clk);
    drive(45);
    wait_result("mid12", 5);
    wait_result("mid45", 0);
  endtask

  task automatic test_overflow();
    sel7 = 1'b1;
    drive(100); wait_result("ovf100", 8);
    drive(99);  wait_result("w7_99", 8);
    drive(127); wait_result("ovf127", 8);
    drive(7);   wait_result("w7_7", 8);
    sel7 = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    rst    = 1'b0;
    value6 = '0;
    value7 = '0;
    sel7   = 1'b0;
    test_reset();
    test_scan();
    test_conversion();
    test_macro();
    test_midconv();
    test_overflow();
    checks++;
    if (sb.size() != 0) begin
      errors++;
      $display("FAIL scoreboard_leftover: size=%0d required 0", sb.size());
    end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule : tb_count_display_7seg
